// File: rtl/aes_pkg.sv
// AES shared definitions: S-box, word helpers and round-key types.
// Used by the key schedule and the cipher datapath.
package aes_pkg;

  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } kx_state_e;

  // Byte 0x00 sits in the top byte; lookup index is {~b, 3'b111}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic bit nk_legal(input int nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel S-box lookups on a 32-bit word.
// Shared between the key schedule and SubBytes.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] w_i,
  output logic [31:0] w_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign w_o[8*b +: 8] = sbox(w_i[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative FIPS-197 key schedule, one word per clock.
// Round keys are held stable with valid high once complete.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [32*Nk-1:0] key_i,
  output logic            busy_o,
  output logic            valid_o,
  output rkey_t           k_sch_o [0:Nr]
);

  localparam int NW = 4 * (Nr + 1);
  localparam logic [5:0] NK6 = 6'(Nk);
  localparam logic [5:0] LAST = 6'(NW - 1);
  localparam logic [2:0] PH_MAX = 3'(Nk - 1);

  if (!nk_legal(Nk) || Nr != Nk + 6) begin : g_bad_cfg
    $error("aes_key_expand: Nk must be 4, 6 or 8");
  end

  kx_state_e   state_q, state_d;
  logic [31:0] w_q [NW];
  logic [5:0]  idx_q, idx_d;
  logic [2:0]  ph_q, ph_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        load, step;

  logic [31:0] prev_w, old_w, sub_in, sub_out, temp, new_w;

  assign prev_w = w_q[idx_q - 6'd1];
  assign old_w  = w_q[idx_q - NK6];
  assign sub_in = (ph_q == 3'd0) ? rot_word(prev_w) : prev_w;

  aes_sub_word u_sub (
    .w_i (sub_in),
    .w_o (sub_out)
  );

  always_comb begin
    temp = prev_w;
    if (ph_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (Nk == 8 && ph_q == 3'd4) begin
      temp = sub_out;
    end
  end

  assign new_w = old_w ^ temp;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        step = 1'b1;
        if (idx_q == LAST) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    ph_d   = ph_q;
    rcon_d = rcon_q;
    if (load) begin
      idx_d  = NK6;
      ph_d   = 3'd0;
      rcon_d = 8'h01;
    end else if (step) begin
      idx_d  = idx_q + 6'd1;
      ph_d   = (ph_q == PH_MAX) ? 3'd0 : ph_q + 3'd1;
      if (ph_q == 3'd0) rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ph_q    <= '0;
      rcon_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      rcon_q  <= rcon_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NW; j++) w_q[j] <= '0;
    end else if (load) begin
      for (int j = 0; j < Nk; j++) begin
        w_q[j] <= key_i[32*(Nk-j)-1 -: 32];
      end
    end else if (step) begin
      w_q[idx_q] <= new_w;
    end
  end

  assign busy_o  = (state_q == ST_EXPAND);
  assign valid_o = (state_q == ST_DONE);

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign k_sch_o[r] = {w_q[4*r], w_q[4*r+1],
                         w_q[4*r+2], w_q[4*r+3]};
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand with Nk = 4, 6 and 8
// against FIPS-197 reference round keys.
module tb_aes_key_expand;

  localparam logic [127:0] KA  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KA1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KA10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KB  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KB1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] KB10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KZ1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KZ10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [191:0] K6 =
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K8 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] ALL = '1;
  localparam logic [127:0] LOW = 128'hffffffff;
  localparam logic [127:0] HIGH = {32'hffffffff, 96'h0};

  logic clk = 1'b0;
  logic rst;
  logic st4, st6, st8;
  logic [127:0] k4;
  logic [191:0] k6;
  logic [255:0] k8;
  logic b4, b6, b8, v4, v6, v8;
  logic [127:0] ks4 [0:10];
  logic [127:0] ks6 [0:12];
  logic [127:0] ks8 [0:14];

  always #5 clk = ~clk;

  aes_key_expand #(.Nk(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(st4), .key_i(k4),
    .busy_o(b4), .valid_o(v4), .k_sch_o(ks4)
  );
  aes_key_expand #(.Nk(6)) dut6 (
    .clk(clk), .rst(rst), .start_i(st6), .key_i(k6),
    .busy_o(b6), .valid_o(v6), .k_sch_o(ks6)
  );
  aes_key_expand #(.Nk(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(st8), .key_i(k8),
    .busy_o(b8), .valid_o(v8), .k_sch_o(ks8)
  );

  typedef struct {
    int           nk;
    logic [255:0] key;
    int           lat;
    int           r;
    logic [127:0] exp;
    logic [127:0] msk;
  } vec_t;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  function automatic logic vld(input int nk);
    case (nk)
      4: return v4;
      6: return v6;
      default: return v8;
    endcase
  endfunction

  function automatic logic bsy(input int nk);
    case (nk)
      4: return b4;
      6: return b6;
      default: return b8;
    endcase
  endfunction

  function automatic logic [127:0] rk(input int nk, input int r);
    case (nk)
      4: return (r <= 10) ? ks4[r] : '0;
      6: return (r <= 12) ? ks6[r] : '0;
      default: return (r <= 14) ? ks8[r] : '0;
    endcase
  endfunction

  // Pulse start, then count edges from E0 until valid.
  task automatic run(input int nk, input logic [255:0] k,
                     output int lat, output int nb, output logic v0);
    @(negedge clk);
    case (nk)
      4: begin k4 = k[255:128]; st4 = 1'b1; end
      6: begin k6 = k[255:64]; st6 = 1'b1; end
      default: begin k8 = k; st8 = 1'b1; end
    endcase
    @(negedge clk);
    st4 = 1'b0; st6 = 1'b0; st8 = 1'b0;
    v0 = vld(nk);
    lat = 0;
    nb = 0;
    while (!vld(nk) && lat < 100) begin
      if (bsy(nk)) nb++;
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs [12];

  initial begin
    int lat, nb;
    logic v0;
    logic [127:0] acc;

    vecs[0]  = '{4, {KA, 128'h0}, 40, 1, KA1, ALL};
    vecs[1]  = '{4, {KA, 128'h0}, 40, 10, KA10, ALL};
    vecs[2]  = '{4, {KA, 128'h0}, 40, 0, KA, ALL};
    vecs[3]  = '{4, {KB, 128'h0}, 40, 1, KB1, ALL};
    vecs[4]  = '{4, {KB, 128'h0}, 40, 10, KB10, ALL};
    vecs[5]  = '{4, 256'h0, 40, 1, KZ1, ALL};
    vecs[6]  = '{4, 256'h0, 40, 10, KZ10, ALL};
    vecs[7]  = '{6, {K6, 64'h0}, 46, 12, 128'h01002202, LOW};
    vecs[8]  = '{6, {K6, 64'h0}, 46, 1,
                 128'h62f8ead2522c6b7bfe0c91f72402f5a5, ALL};
    vecs[9]  = '{8, K8, 52, 14, 128'h706c631e, LOW};
    vecs[10] = '{8, K8, 52, 3, {32'ha8b09c1a, 96'h0}, HIGH};
    vecs[11] = '{8, K8, 52, 2,
                 128'h9ba354118e6925afa51a8b5f2067fcde, ALL};

    rst = 1'b1;
    st4 = 1'b0; st6 = 1'b0; st8 = 1'b0;
    k4 = '0; k6 = '0; k8 = '0;
    @(negedge clk);
    chk("rst_busy", 128'(b4), 128'(0));
    chk("rst_valid", 128'(v4), 128'(0));
    chk("rst_rk10", ks4[10], 128'h0);
    chk("rst_rk14_nk8", ks8[14], 128'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run(vecs[i].nk, vecs[i].key, lat, nb, v0);
      chk($sformatf("vec%0d_latency", i), 128'(lat),
          128'(vecs[i].lat));
      chk($sformatf("vec%0d_busy_cycles", i), 128'(nb),
          128'(vecs[i].lat));
      chk($sformatf("vec%0d_k_sch%0d", i, vecs[i].r),
          rk(vecs[i].nk, vecs[i].r) & vecs[i].msk,
          vecs[i].exp & vecs[i].msk);
    end

    // Start during EXPAND with a new key must be ignored.
    @(negedge clk);
    k4 = KA; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    lat = 0;
    while (!v4 && lat < 100) begin
      if (lat == 10) begin
        st4 = 1'b1; k4 = KB;
      end else begin
        st4 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    st4 = 1'b0;
    chk("ignore_start_latency", 128'(lat), 128'(40));
    chk("ignore_start_rk10", ks4[10], KA10);
    repeat (5) @(negedge clk);
    chk("done_hold_valid", 128'(v4), 128'(1));
    chk("done_hold_rk10", ks4[10], KA10);

    // Fresh start from DONE with key B.
    run(4, {KB, 128'h0}, lat, nb, v0);
    chk("restart_valid_drop", 128'(v0), 128'(0));
    chk("restart_latency", 128'(lat), 128'(40));
    chk("restart_rk10", ks4[10], KB10);

    // Asynchronous reset mid-expansion.
    @(negedge clk);
    k4 = KA; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    acc = '0;
    for (int r = 0; r <= 10; r++) acc = acc | ks4[r];
    chk("abort_busy", 128'(b4), 128'(0));
    chk("abort_valid", 128'(v4), 128'(0));
    chk("abort_k_sch_zero", acc, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    run(4, {KA, 128'h0}, lat, nb, v0);
    chk("post_abort_latency", 128'(lat), 128'(40));
    chk("post_abort_rk1", ks4[1], KA1);
    chk("post_abort_rk10", ks4[10], KA10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative FIPS-197 key schedule generator that sits directly upstream of the AES cipher core and drives its k_sch[0:Nr] round-key array.
- Computes one 32-bit schedule word per clock after a start pulse, then holds all round keys stable with valid asserted until the next start.
- Supports AES-128/192/256 by parameter.

Parameters:
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
- Nr, Nk+6, number of rounds; derived, do not override.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to expand key; honoured only in IDLE or DONE.
- key  in  32*Nk  cipher key, FIPS byte order; key[32*Nk-1 -: 8] is key byte 0; sampled only on the accepting edge.
- busy  out  1  high while expansion is in progress.
- valid  out  1  high when k_sch holds a complete schedule for the last accepted key.
- k_sch  out  128 x [0:Nr]  round keys; k_sch[r] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r][31:24] as the first byte.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy=0, valid=0.
  - All schedule words, and therefore every k_sch entry, are cleared to 0.
  - Word index and Rcon are cleared.
- FSM states: IDLE, EXPAND, DONE.
- Accepting edge E0 (start=1 in IDLE or DONE):
  - w[0..Nk-1] are loaded from key.
  - Index i is set to Nk and Rcon to 8'h01.
  - State goes to EXPAND; busy=1 and valid=0 from the next cycle.
- EXPAND, one word per edge:
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon, 24'h0}, then Rcon = xtime(Rcon).
  - Else if Nk==8 and i mod Nk == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; i increments.
- Modulo tracking:
  - Use a 0..Nk-1 phase counter, not a divider.
  - RotWord is a left byte rotate: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
  - xtime is shift-left-1, XORed with 8'h1b if the msb was set.
- Completion:
  - Writing the last word w[4(Nr+1)-1] moves the FSM to DONE; busy=0 and valid=1 from the next cycle.
  - Expansion length N = 4(Nr+1)-Nk edges after E0: 40 (Nk=4), 46 (Nk=6), 52 (Nk=8).
- DONE:
  - k_sch is fully stable; valid stays high indefinitely.
  - A new start re-enters EXPAND and drops valid on the following cycle.
- Boundary rules:
  - start during EXPAND is ignored; the current expansion completes with the originally sampled key.
  - key changes after E0 have no effect.
  - start in DONE on the same edge as nothing else: treated as a fresh E0. Words w[0..Nk-1] are overwritten immediately; higher words are rewritten progressively. Consumers must gate on valid.
  - rst asserted mid-EXPAND aborts immediately: state IDLE, outputs as at reset, partial words discarded.
  - k_sch entries change only on E0 and EXPAND edges, never in IDLE or DONE.
- Storage and output:
  - Storage is 4(Nr+1) x 32-bit words; k_sch is pure wiring from that storage.
  - Index width is 6 bits, sufficient for 60 words.

Decomposition:
- Shared package aes_pkg holds:
  - SBOX constant.
  - SubWord and RotWord functions, with byte order as defined above.
  - xtime function.
  - Legal-Nk check.
  - Round-key array typedef: logic [127:0] with range [0:Nr] as a parameterised type alias.
- The cipher core migrates to the same package.
- One natural sub-module: aes_sub_word, four parallel S-box lookups, 32-bit in and out. It is reusable by the cipher's SubBytes.

Test Plan:
- Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - valid rises exactly 40 cycles after the accepting edge.
  - k_sch[1] = a0fafe1788542cb123a339392a6c7605.
  - k_sch[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - busy is high for exactly 40 cycles.
- Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> valid after 46 cycles; w[51] (k_sch[12][31:0]) = 01002202.
- Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> valid after 52 cycles; w[59] (k_sch[14][31:0]) = 706c631e.
- Nk=4, start with key A, then start again with key B at cycle 10 and key input changed:
  - The second start is ignored.
  - After 40 cycles, k_sch[10] matches the expansion of key A.
  - A later start in DONE with key B drops valid next cycle and yields B's schedule 40 cycles later.
- Assert rst at cycle 20 of an expansion -> busy=0, valid=0, all k_sch=0 asynchronously; a start after release yields the correct schedule with full 40-cycle latency.
